// File: rtl/serial_adder_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_if
//  Description : Operand-request / result-response handshake bundle for the
//                bit-serial adder. The master drives operands and accepts
//                results. The slave (the adder) does the reverse.
//  Revision    : 1.0  initial release
// ============================================================================
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder
//  Description : Bit-serial unsigned adder. It captures two WIDTH-bit operands
//                and a carry-in, then adds them LSB-first through one
//                full-adder slice, one bit per clock. It returns the sum and
//                carry-out over a valid/ready handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    serial_adder_if.slave     bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0]       c_idle = 2'd0;
    localparam logic [1:0]       c_run  = 2'd1;
    localparam logic [1:0]       c_done = 2'd2;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_sum_sr;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;

    logic [1:0]       w_fa;
    logic [WIDTH-1:0] w_sum_next;

    // Single-bit full adder: returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (y & ci) | (ci & x), x ^ y ^ ci};
    endfunction

    assign w_fa = full_add(r_a_sr[0], r_b_sr[0], r_carry);

    // The new sum bit enters at the MSB, so after WIDTH shifts bit 0 is the LSB.
    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign w_sum_next = w_fa[0];
        end else begin : g_sum_wn
            assign w_sum_next = {w_fa[0], r_sum_sr[WIDTH-1:1]};
        end
    endgenerate

    // Control FSM and serial datapath: capture in IDLE, shift in RUN, hold in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_idle;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_sum_sr <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (bus.in_valid) begin
                        r_a_sr   <= bus.a;
                        r_b_sr   <= bus.b;
                        r_carry  <= bus.cin;
                        r_cnt    <= '0;
                        r_sum_sr <= '0;
                        r_state  <= c_run;
                    end
                end
                c_run: begin
                    r_carry  <= w_fa[1];
                    r_sum_sr <= w_sum_next;
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_cnt    <= r_cnt + c_one;
                    if (r_cnt == c_last) begin
                        r_state <= c_done;
                    end
                end
                c_done: begin
                    // The result stays registered until the next accept, even after it is consumed.
                    if (bus.out_ready) begin
                        r_state <= c_idle;
                    end
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == c_idle);
    assign bus.out_valid = (r_state == c_done);
    assign bus.busy      = (r_state == c_run) || (r_state == c_done);
    assign bus.sum       = r_sum_sr;
    assign bus.cout      = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder
//  Description : Self-checking bench for serial_adder. It drives WIDTH=8, 1 and
//                16 instances and compares every cycle against an arithmetic
//                reference.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  iv  = 3'b000;
    logic [15:0] a   = '0;
    logic [15:0] b   = '0;
    logic        cin = 1'b0;
    logic        out_ready = 1'b0;
    logic        chk_en = 1'b0;

    int checks = 0;
    int errors = 0;

    int wdt [3] = '{8, 1, 16};

    logic        o_ir   [3];
    logic        o_ov   [3];
    logic        o_busy [3];
    logic        o_cout [3];
    logic [15:0] o_sum  [3];

    serial_adder_if #(.WIDTH(8))  if8  ();
    serial_adder_if #(.WIDTH(1))  if1  ();
    serial_adder_if #(.WIDTH(16)) if16 ();

    assign if8.in_valid  = iv[0];
    assign if8.a         = a[7:0];
    assign if8.b         = b[7:0];
    assign if8.cin       = cin;
    assign if8.out_ready = out_ready;
    assign if1.in_valid  = iv[1];
    assign if1.a         = a[0:0];
    assign if1.b         = b[0:0];
    assign if1.cin       = cin;
    assign if1.out_ready = out_ready;
    assign if16.in_valid  = iv[2];
    assign if16.a         = a;
    assign if16.b         = b;
    assign if16.cin       = cin;
    assign if16.out_ready = out_ready;

    assign o_ir[0] = if8.in_ready;   assign o_ov[0] = if8.out_valid;
    assign o_busy[0] = if8.busy;     assign o_cout[0] = if8.cout;
    assign o_sum[0] = {8'h00, if8.sum};
    assign o_ir[1] = if1.in_ready;   assign o_ov[1] = if1.out_valid;
    assign o_busy[1] = if1.busy;     assign o_cout[1] = if1.cout;
    assign o_sum[1] = {15'h0000, if1.sum};
    assign o_ir[2] = if16.in_ready;  assign o_ov[2] = if16.out_valid;
    assign o_busy[2] = if16.busy;    assign o_cout[2] = if16.cout;
    assign o_sum[2] = if16.sum;

    serial_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
    serial_adder #(.WIDTH(1))  dut1  (.clk(clk), .rst(rst), .bus(if1));
    serial_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));

    always #5 clk = ~clk;

    // Reference: {cout, sum} = a + b + cin, all truncated to w bits.
    function automatic logic [16:0] ref_add(input int w, input logic [15:0] x,
                                            input logic [15:0] y, input logic c);
        logic [16:0] m;
        logic [16:0] f;
        m = (17'd1 << w) - 17'd1;
        f = ({1'b0, x} & m) + ({1'b0, y} & m) + {16'd0, c};
        return {f[w], f[15:0] & m[15:0]};
    endfunction

    // Transaction-level model. Phase 0=idle, 1=computing, 2=result offered.
    int          m_st   [3];
    int          m_left [3];
    logic [16:0] m_res  [3];
    logic [15:0] m_sum  [3];
    logic        m_cout [3];

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_st[k]   <= 0;
                m_left[k] <= 0;
                m_res[k]  <= '0;
                m_sum[k]  <= '0;
                m_cout[k] <= 1'b0;
            end else if (m_st[k] == 0) begin
                if (iv[k]) begin
                    m_res[k]  <= ref_add(wdt[k], a, b, cin);
                    m_left[k] <= wdt[k];
                    m_st[k]   <= 1;
                end
            end else if (m_st[k] == 1) begin
                m_left[k] <= m_left[k] - 1;
                if (m_left[k] == 1) begin
                    m_st[k]   <= 2;
                    m_sum[k]  <= m_res[k][15:0];
                    m_cout[k] <= m_res[k][16];
                end
            end else begin
                if (out_ready) m_st[k] <= 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("in_ready[%0d]", k),  32'(o_ir[k]),   32'(m_st[k] == 0));
                chk($sformatf("out_valid[%0d]", k), 32'(o_ov[k]),   32'(m_st[k] == 2));
                chk($sformatf("busy[%0d]", k),      32'(o_busy[k]), 32'(m_st[k] != 0));
                if (m_st[k] != 1) begin
                    chk($sformatf("sum[%0d]", k),  32'(o_sum[k]),  32'(m_sum[k]));
                    chk($sformatf("cout[%0d]", k), 32'(o_cout[k]), 32'(m_cout[k]));
                end
            end
        end
    end

    task automatic timeout_fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timeout waiting for DUT", nm);
    endtask

    // One transaction on instance k. The literal expectations pin the model.
    task automatic do_op(input int k, input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic tc, input int stall, input logic lit,
                         input logic [15:0] es, input logic ec, input logic keep,
                         input logic [15:0] na, input logic [15:0] nb);
        int  n;
        logic was;
        a = ta; b = tb_v; cin = tc; iv[k] = 1'b1; out_ready = 1'b0;
        n = 0;
        forever begin
            was = o_ir[k];
            @(posedge clk); #1;
            n++;
            if (was) break;
            if (n > 200) begin timeout_fail("accept"); break; end
        end
        if (keep) begin
            a = na; b = nb;
        end else begin
            iv[k] = 1'b0;
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        end
        n = 0;
        while (!o_ov[k] && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!o_ov[k]) timeout_fail("out_valid");
        chk($sformatf("latency[%0d]", k), 32'(n), 32'(wdt[k]));
        repeat (stall) begin @(posedge clk); #1; end
        if (lit) begin
            chk($sformatf("lit_sum[%0d]", k),  32'(o_sum[k]),  32'(es));
            chk($sformatf("lit_cout[%0d]", k), 32'(o_cout[k]), 32'(ec));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk($sformatf("post_ready[%0d]", k), 32'(o_ir[k]), 32'd1);
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset_sum",   32'(o_sum[0]), 32'd0);
        chk("reset_ready", 32'(o_ir[0]),  32'd1);
        chk("reset_valid", 32'(o_ov[0]),  32'd0);

        // Directed, WIDTH=8
        do_op(0, 16'h00, 16'h00, 1'b0, 0, 1'b1, 16'h00, 1'b0, 1'b0, 0, 0);
        do_op(0, 16'hFF, 16'h01, 1'b0, 0, 1'b1, 16'h00, 1'b1, 1'b0, 0, 0);
        do_op(0, 16'hA5, 16'h5A, 1'b1, 1, 1'b1, 16'h00, 1'b1, 1'b0, 0, 0);
        do_op(0, 16'h3C, 16'h42, 1'b0, 0, 1'b1, 16'h7E, 1'b0, 1'b0, 0, 0);
        do_op(0, 16'h80, 16'h80, 1'b1, 5, 1'b1, 16'h01, 1'b1, 1'b0, 0, 0);

        // Request held high through RUN/DONE. The second operands must not disturb the first result.
        do_op(0, 16'h01, 16'h01, 1'b0, 2, 1'b1, 16'h02, 1'b0, 1'b1, 16'h11, 16'h22);
        do_op(0, 16'h11, 16'h22, 1'b0, 0, 1'b1, 16'h33, 1'b0, 1'b0, 0, 0);

        // Asynchronous reset in the middle of a computation.
        a = 16'hF0; b = 16'h0F; cin = 1'b0; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(o_ov[0]),   32'd0);
        chk("arst_sum",   32'(o_sum[0]),  32'd0);
        chk("arst_cout",  32'(o_cout[0]), 32'd0);
        chk("arst_ready", 32'(o_ir[0]),   32'd1);
        chk("arst_busy",  32'(o_busy[0]), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        do_op(0, 16'h01, 16'h02, 1'b0, 0, 1'b1, 16'h03, 1'b0, 1'b0, 0, 0);

        // Width corner cases.
        do_op(1, 16'h1, 16'h1, 1'b1, 0, 1'b1, 16'h1, 1'b1, 1'b0, 0, 0);
        do_op(1, 16'h0, 16'h0, 1'b0, 0, 1'b1, 16'h0, 1'b0, 1'b0, 0, 0);
        do_op(2, 16'hFFFF, 16'h0001, 1'b0, 0, 1'b1, 16'h0000, 1'b1, 1'b0, 0, 0);
        do_op(2, 16'h1234, 16'h4321, 1'b1, 0, 1'b1, 16'h5556, 1'b0, 1'b0, 0, 0);

        // Random operands across all instances, checked by the model.
        for (int i = 0; i < 1000; i++) begin
            do_op($urandom_range(0, 2), 16'($urandom), 16'($urandom), 1'($urandom),
                  $urandom_range(0, 2), 1'b0, 16'h0, 1'b0, 1'b0, 0, 0);
        end

        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
